// File: rtl/wb_dual_commit.sv
// wb_dual_commit
//   Write-back commit unit for the two-lane pipeline. Decodes the WB select of
//   lane A (older) and lane B (younger), enqueues writing lanes in program order
//   into a small commit queue, and drains one entry per cycle into the single
//   register-file write port.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-low reset
//   a_* / b_*           lane valid, WB select, destination and candidate values
//   ready_out           both lanes sampled this cycle (M/WB register enable)
//   rf_we/addr/data     registered register-file write port
//   rf_r7               registered write targets r7 (PC)
//   pending_mask        one bit per register with an uncommitted write
//   occupancy           queue entry count
//   bad_sel             sticky flag for a reserved WB code on a valid lane
module wb_dual_commit #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int AW    = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       a_valid,
    input  logic [2:0]                 a_wb_sel,
    input  logic [AW-1:0]              a_dest,
    input  logic [DW-1:0]              a_pc1,
    input  logic [DW-1:0]              a_alu,
    input  logic [DW-1:0]              a_mem,
    input  logic [DW-1:0]              a_zpad,
    input  logic                       b_valid,
    input  logic [2:0]                 b_wb_sel,
    input  logic [AW-1:0]              b_dest,
    input  logic [DW-1:0]              b_pc1,
    input  logic [DW-1:0]              b_alu,
    input  logic [DW-1:0]              b_mem,
    input  logic [DW-1:0]              b_zpad,
    output logic                       ready_out,
    output logic                       rf_we,
    output logic [AW-1:0]              rf_addr,
    output logic [DW-1:0]              rf_data,
    output logic                       rf_r7,
    output logic [(2**AW)-1:0]         pending_mask,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       bad_sel
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] q_dest [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          a_write;
    logic          b_write;
    logic [DW-1:0] a_value;
    logic [DW-1:0] b_value;
    logic          a_reserved;
    logic          b_reserved;
    logic [CW-1:0] enq_n;
    logic          pop;

    // Returns {writes, value}; codes 101..111 yield no write.
    function automatic logic [DW:0] decode(
        input logic [2:0]    sel,
        input logic [DW-1:0] pc1,
        input logic [DW-1:0] alu,
        input logic [DW-1:0] mem,
        input logic [DW-1:0] zpad
    );
        logic [DW:0] r;
        r = '0;
        case (sel)
            3'b001:  r = {1'b1, alu};
            3'b010:  r = {1'b1, mem};
            3'b011:  r = {1'b1, zpad};
            3'b100:  r = {1'b1, pc1};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        logic [DW:0] a_dec;
        logic [DW:0] b_dec;
        a_dec      = decode(a_wb_sel, a_pc1, a_alu, a_mem, a_zpad);
        b_dec      = decode(b_wb_sel, b_pc1, b_alu, b_mem, b_zpad);
        a_write    = a_valid && a_dec[DW];
        b_write    = b_valid && b_dec[DW];
        a_value    = a_dec[DW-1:0];
        b_value    = b_dec[DW-1:0];
        a_reserved = a_valid && a_wb_sel[2] && (a_wb_sel[1:0] != 2'b00);
        b_reserved = b_valid && b_wb_sel[2] && (b_wb_sel[1:0] != 2'b00);
        ready_out  = (count <= CW'(DEPTH - 2));
        enq_n      = ready_out ? (CW'(a_write) + CW'(b_write)) : '0;
        pop        = (count != '0);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
            rf_r7   <= 1'b0;
            bad_sel <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_dest[i] <= '0;
                q_data[i] <= '0;
            end
        end else begin
            if (ready_out) begin
                if (a_write) begin
                    q_dest[tail] <= a_dest;
                    q_data[tail] <= a_value;
                end
                // B lands behind A when both write, otherwise at the tail.
                if (b_write) begin
                    q_dest[a_write ? tail + PW'(1) : tail] <= b_dest;
                    q_data[a_write ? tail + PW'(1) : tail] <= b_value;
                end
                tail <= tail + PW'(enq_n);
                if (a_reserved || b_reserved)
                    bad_sel <= 1'b1;
            end
            rf_we <= pop;
            rf_r7 <= pop && (q_dest[head] == AW'(7));
            if (pop) begin
                rf_addr <= q_dest[head];
                rf_data <= q_data[head];
                head    <= head + PW'(1);
            end
            count <= count + enq_n - CW'(pop);
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count)
                pending_mask[q_dest[head + PW'(i)]] = 1'b1;
        end
        if (rf_we)
            pending_mask[rf_addr] = 1'b1;
    end

    assign occupancy = count;

    count_bound: assert property (@(posedge clock) disable iff (!reset) count <= CW'(DEPTH));

endmodule

// File: tb/tb_wb_dual_commit.sv
// tb_wb_dual_commit
//   Directed-vector bench for wb_dual_commit with DEPTH=4, DW=16, AW=3.
//   Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_wb_dual_commit;

    logic        clock;
    logic        reset;
    logic        a_valid;
    logic [2:0]  a_wb_sel;
    logic [2:0]  a_dest;
    logic [15:0] a_pc1, a_alu, a_mem, a_zpad;
    logic        b_valid;
    logic [2:0]  b_wb_sel;
    logic [2:0]  b_dest;
    logic [15:0] b_pc1, b_alu, b_mem, b_zpad;
    logic        ready_out;
    logic        rf_we;
    logic [2:0]  rf_addr;
    logic [15:0] rf_data;
    logic        rf_r7;
    logic [7:0]  pending_mask;
    logic [2:0]  occupancy;
    logic        bad_sel;

    int checks;
    int failures;

    wb_dual_commit #(.DEPTH(4), .DW(16), .AW(3)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_wb_sel(a_wb_sel), .a_dest(a_dest),
        .a_pc1(a_pc1), .a_alu(a_alu), .a_mem(a_mem), .a_zpad(a_zpad),
        .b_valid(b_valid), .b_wb_sel(b_wb_sel), .b_dest(b_dest),
        .b_pc1(b_pc1), .b_alu(b_alu), .b_mem(b_mem), .b_zpad(b_zpad),
        .ready_out(ready_out), .rf_we(rf_we), .rf_addr(rf_addr),
        .rf_data(rf_data), .rf_r7(rf_r7), .pending_mask(pending_mask),
        .occupancy(occupancy), .bad_sel(bad_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Distinct per-source values so a wrong mux selection is visible.
    task automatic idle_inputs();
        a_valid = 0; a_wb_sel = 3'b000; a_dest = 0;
        a_pc1 = 16'hA0A0; a_alu = 16'hA1A1; a_mem = 16'hA2A2; a_zpad = 16'hA3A3;
        b_valid = 0; b_wb_sel = 3'b000; b_dest = 0;
        b_pc1 = 16'hB0B0; b_alu = 16'hB1B1; b_mem = 16'hB2B2; b_zpad = 16'hB3B3;
    endtask

    task automatic check_rf(input string tag, input logic we, input logic [2:0] addr, input logic [15:0] data);
        check({tag, "_we"}, 32'(rf_we), 32'(we));
        if (we) begin
            check({tag, "_addr"}, 32'(rf_addr), 32'(addr));
            check({tag, "_data"}, 32'(rf_data), 32'(data));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        idle_inputs();

        // Reset then idle
        reset = 0;
        tick(); tick();
        reset = 1;
        tick();
        check("rst_ready", 32'(ready_out), 1);
        check("rst_we", 32'(rf_we), 0);
        check("rst_mask", 32'(pending_mask), 0);
        check("rst_occ", 32'(occupancy), 0);
        check("rst_bad", 32'(bad_sel), 0);

        // Single write from lane A
        a_valid = 1; a_wb_sel = 3'b001; a_dest = 3; a_alu = 16'h1234;
        tick();
        idle_inputs();
        check("single_mask_k", 32'(pending_mask), 32'h08);
        check("single_occ_k", 32'(occupancy), 1);
        check("single_we_k", 32'(rf_we), 0);
        tick();
        check_rf("single_k1", 1, 3, 16'h1234);
        check("single_r7", 32'(rf_r7), 0);
        check("single_mask_k1", 32'(pending_mask), 32'h08);
        tick();
        check("single_we_k2", 32'(rf_we), 0);
        check("single_mask_k2", 32'(pending_mask), 0);

        // Dual write to the same destination
        a_valid = 1; a_wb_sel = 3'b010; a_dest = 5; a_mem = 16'hAAAA;
        b_valid = 1; b_wb_sel = 3'b011; b_dest = 5; b_zpad = 16'h0055;
        tick();
        idle_inputs();
        check("dual_occ", 32'(occupancy), 2);
        check("dual_mask", 32'(pending_mask), 32'h20);
        tick();
        check_rf("dual_first", 1, 5, 16'hAAAA);
        tick();
        check_rf("dual_second", 1, 5, 16'h0055);
        tick();
        check("dual_done", 32'(rf_we), 0);

        // Lane B alone goes to the tail
        b_valid = 1; b_wb_sel = 3'b100; b_dest = 6; b_pc1 = 16'h0606;
        tick();
        idle_inputs();
        check("bonly_mask", 32'(pending_mask), 32'h40);
        tick();
        check_rf("bonly", 1, 6, 16'h0606);
        tick();

        // Backpressure
        a_valid = 1; a_wb_sel = 3'b001; a_dest = 1; a_alu = 16'h0011;
        b_valid = 1; b_wb_sel = 3'b001; b_dest = 2; b_alu = 16'h0022;
        tick();
        check("bp_occ1", 32'(occupancy), 2);
        check("bp_ready1", 32'(ready_out), 1);
        a_dest = 3; a_alu = 16'h0033;
        b_dest = 4; b_alu = 16'h0044;
        tick();
        check("bp_occ2", 32'(occupancy), 3);
        check("bp_ready2", 32'(ready_out), 0);
        check_rf("bp_w1", 1, 1, 16'h0011);
        check("bp_mask2", 32'(pending_mask), 32'h1E);
        // Changed while stalled: must not be enqueued
        a_dest = 6; a_alu = 16'h0066;
        b_dest = 6; b_alu = 16'h0066;
        tick();
        idle_inputs();
        check("bp_occ3", 32'(occupancy), 2);
        check("bp_ready3", 32'(ready_out), 1);
        check_rf("bp_w2", 1, 2, 16'h0022);
        tick();
        check_rf("bp_w3", 1, 3, 16'h0033);
        check("bp_occ4", 32'(occupancy), 1);
        tick();
        check_rf("bp_w4", 1, 4, 16'h0044);
        check("bp_occ5", 32'(occupancy), 0);
        tick();
        check("bp_done", 32'(rf_we), 0);
        check("bp_mask_done", 32'(pending_mask), 0);

        // PC write
        a_valid = 1; a_wb_sel = 3'b100; a_dest = 7; a_pc1 = 16'h0021;
        tick();
        idle_inputs();
        check("pc_mask", 32'(pending_mask), 32'h80);
        tick();
        check_rf("pc", 1, 7, 16'h0021);
        check("pc_r7", 32'(rf_r7), 1);
        tick();
        check("pc_r7_clear", 32'(rf_r7), 0);

        // Reserved code on lane B
        b_valid = 1; b_wb_sel = 3'b110; b_dest = 2;
        tick();
        idle_inputs();
        check("rsv_occ", 32'(occupancy), 0);
        check("rsv_bad", 32'(bad_sel), 1);
        tick();
        check("rsv_we", 32'(rf_we), 0);
        check("rsv_bad_sticky", 32'(bad_sel), 1);

        // Valid select but lane invalid
        a_valid = 0; a_wb_sel = 3'b001; a_dest = 4;
        tick();
        idle_inputs();
        check("inv_occ", 32'(occupancy), 0);
        check("inv_mask", 32'(pending_mask), 0);
        tick();
        check("inv_we", 32'(rf_we), 0);

        // Reset mid-drain with three entries queued
        a_valid = 1; a_wb_sel = 3'b001; a_dest = 1; a_alu = 16'h0101;
        b_valid = 1; b_wb_sel = 3'b001; b_dest = 2; b_alu = 16'h0202;
        tick();
        a_dest = 3; b_dest = 4;
        tick();
        idle_inputs();
        check("mid_occ", 32'(occupancy), 3);
        reset = 0;
        tick();
        reset = 1;
        check("mid_rst_occ", 32'(occupancy), 0);
        check("mid_rst_we", 32'(rf_we), 0);
        check("mid_rst_mask", 32'(pending_mask), 0);
        check("mid_rst_bad", 32'(bad_sel), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_after_we", 32'(rf_we), 0);
        end
        check("mid_after_occ", 32'(occupancy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_dual_commit.md
Name: wb_dual_commit

Overview:
- Write-back commit unit for the two-lane superscalar pipeline. It sits after the two M/WB pipeline registers (lane A older, lane B younger).
- Each cycle it decodes the 3-bit WB select of each valid lane and enqueues the write-back value with its destination into an in-order commit queue.
- It drains the queue through the single register-file write port, one write per cycle.
- Its ready output drives the enable of both M/WB registers, and it exports a pending-destination mask to the hazard unit.

Parameters:
- DEPTH, 4, commit queue entries; power of two, at least 2.
- DW, 16, data width.
- AW, 3, register address width (8 architectural registers; R7 = PC).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- a_valid  input  1  lane A instruction valid (from M/WB Valid_out).
- a_wb_sel  input  3  lane A WB select code.
- a_dest  input  AW  lane A destination register.
- a_pc1, a_alu, a_mem, a_zpad  input  DW each  lane A PC+1, ALU result, memory read data, zero-padded immediate.
- b_valid, b_wb_sel, b_dest, b_pc1, b_alu, b_mem, b_zpad  input  as lane A  lane B equivalents.
- ready_out  output  1  both lanes are sampled this cycle; drives the M/WB enable.
- rf_we  output  1  register-file write enable (registered).
- rf_addr  output  AW  register-file write address (registered).
- rf_data  output  DW  register-file write data (registered).
- rf_r7  output  1  high with rf_we when rf_addr==7 (PC write notification).
- pending_mask  output  2**AW  bit r set while any uncommitted write to r exists.
- occupancy  output  log2(DEPTH)+1  current queue entry count.
- bad_sel  output  1  sticky: a reserved WB code was seen on a valid lane.

Behaviour:
- Reset is active-low and synchronous: when reset==0 at a rising clock edge, every register clears.
  - Queue count = 0; head and tail pointers = 0.
  - rf_we = 0, rf_addr = 0, rf_data = 0, rf_r7 = 0, bad_sel = 0.
  - As a result ready_out = 1, pending_mask = 0, occupancy = 0.
  - Reset mid-operation discards all queued entries, and no rf_we is issued in the cycle after reset.
- WB select decode for lane X:
  - 000 = no write.
  - 001 = X_alu.
  - 010 = X_mem.
  - 011 = X_zpad.
  - 100 = X_pc1.
  - 101/110/111 = reserved: no write, and bad_sel sets to 1 and holds until reset.
- A lane "writes" only when X_valid==1 and its code is 001..100.
- ready_out is combinational from the registered count: ready_out = (DEPTH - count) >= 2. A pop in the same cycle does not raise ready_out.
- Accept: on an edge where ready_out==1, each writing lane is enqueued.
  - Lane A goes at tail and lane B at tail+1 if both write; B goes at tail if only B writes.
  - Pointers wrap modulo DEPTH.
  - When ready_out==0, lane inputs are ignored; upstream holds them because the M/WB enable is low.
- Drain: on every edge with count>0 (pre-edge value), the head entry is popped into rf_addr/rf_data, with rf_we=1 and rf_r7=(addr==7). Otherwise rf_we=0, and rf_addr/rf_data hold their previous values.
- Count update: count_next = count + enq_n - pop, where enq_n is 0..2 and pop is 0/1. Simultaneous enqueue and pop on a full-minus-two or empty queue is legal.
- Latency: an entry accepted at edge k into an empty queue is popped at edge k+1; rf_we is high during the cycle following edge k+1. There is no empty-queue bypass.
- Ordering: strict program order, A before B, and older cycles before newer ones. If both lanes target the same register, two writes are issued and B's value is final.
- pending_mask (combinational): OR of one-hot(dest) over all valid queue entries, plus one-hot(rf_addr) when rf_we==1.
- Overflow cannot occur by construction; count must never exceed DEPTH (assertion).

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, then 1 -> ready_out=1, rf_we=0, pending_mask=0, occupancy=0, bad_sel=0.
- Single write: A valid, sel=001, dest=3, alu=16'h1234; B invalid, accepted at edge k -> pending_mask=8'h08 after edge k; rf_we=1, rf_addr=3, rf_data=16'h1234 after edge k+1; mask clears after edge k+2.
- Dual same-dest: A sel=010 dest=5 mem=16'hAAAA; B sel=011 dest=5 zpad=16'h0055 -> rf writes 16'hAAAA then 16'h0055 on consecutive cycles to r5.
- Backpressure, DEPTH=4: both lanes write for 2 consecutive cycles -> occupancy reaches 3 (4 enqueued, 1 popped) and ready_out=0; inputs changed while stalled are not enqueued; queue drains in order, and ready_out returns to 1 when occupancy <= 2.
- Decode edge cases:
  - A sel=100 dest=7 pc1=16'h0021 -> rf_r7=1, rf_data=16'h0021.
  - B valid with sel=110 -> no enqueue and bad_sel=1 sticky.
  - A sel=001 with a_valid=0 -> no write.
- Reset mid-drain: 3 entries queued, assert reset=0 for one edge -> occupancy=0, rf_we=0 next cycle, and no queued writes emerge afterwards.
